// File: rtl/picoblaze_interrupt_arbiter_if.sv
// Core-side port bus and interrupt handshake of the PicoBlaze interrupt arbiter.
//
// master (core side)    : drives port_id, out_port, write_strobe, read_strobe,
//                         interrupt_ack; receives interrupt, rd_data, rd_hit
// slave  (arbiter side) : the mirror image of master
interface picoblaze_interrupt_arbiter_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic       interrupt_ack;
  logic       interrupt;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  interrupt, rd_data, rd_hit
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output interrupt, rd_data, rd_hit
  );
endinterface

// File: rtl/picoblaze_interrupt_arbiter.sv
// Multi-source interrupt arbiter for the PicoBlaze core.
// Latches rising edges on up to 8 event sources into pending bits, masks and
// prioritises them (index 0 highest), and drives the core's single interrupt
// line. The request is held until interrupt_ack, after which the arbiter stays
// in service until firmware writes an end-of-interrupt (EOI).
//
// Ports
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   src_req  : NUM_SRC event inputs, a 0->1 transition is one event
//   bus      : slave side of the core port bus (port_id/out_port/strobes,
//              interrupt/interrupt_ack handshake, registered rd_data/rd_hit)
//
// Writes: port_id[5] loads the mask, port_id[4] is EOI (SERVICE only).
// Reads : STATUS_PORT, PEND_PORT, MASK_RD_PORT, OVR_PORT, one cycle latency.
module picoblaze_interrupt_arbiter #(
  parameter int         NUM_SRC      = 4,
  parameter logic [7:0] STATUS_PORT  = 8'h01,
  parameter logic [7:0] PEND_PORT    = 8'h02,
  parameter logic [7:0] MASK_RD_PORT = 8'h03,
  parameter logic [7:0] OVR_PORT     = 8'h04
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_SRC-1:0]           src_req,
  picoblaze_interrupt_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] ovr;
  logic [NUM_SRC-1:0] mask;
  logic [2:0]         act_id;
  logic               irq;
  logic [7:0]         rd_data_q;
  logic               rd_hit_q;

  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] eoi_clr;
  logic [2:0]         win_id;
  logic               eoi;
  logic               mask_wr;
  logic [7:0]         status;
  logic [7:0]         rd_next;
  logic               hit_next;

  // read_strobe is informational and out_port is only partly decoded.
  logic unused_bits;
  assign unused_bits = ^{bus.read_strobe, bus.out_port};

  assign bus.interrupt = irq;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_hit    = rd_hit_q;

  // Event detection, write decode and the EOI clear vector.
  // EOI only counts in SERVICE so a stray write elsewhere cannot drop a request.
  always_comb begin
    evt     = src_req & ~src_q;
    req     = pend & mask;
    mask_wr = bus.write_strobe & bus.port_id[5];
    eoi     = bus.write_strobe & bus.port_id[4] & (state == S_SERVICE);
    eoi_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eoi && (act_id == 3'(i))) eoi_clr[i] = 1'b1;
    end
  end

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    win_id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) win_id = 3'(i);
    end
  end

  // Read decode on the full port address; the registered result matches the
  // core's pipelined input mux.
  always_comb begin
    status   = {(state == S_SERVICE), irq, 3'b000, act_id};
    rd_next  = 8'h00;
    hit_next = 1'b1;
    case (bus.port_id)
      STATUS_PORT:  rd_next = status;
      PEND_PORT:    rd_next = 8'(pend);
      MASK_RD_PORT: rd_next = 8'(mask);
      OVR_PORT:     rd_next = 8'(ovr);
      default:      hit_next = 1'b0;
    endcase
  end

  // Pending/overrun bookkeeping, mask register, arbitration FSM and read
  // registers. A new event on the source being cleared by EOI wins for pend,
  // while its overrun is still cleared. act_id returns to 0 at EOI so STATUS
  // reads zero while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= src_req;
      pend      <= '0;
      ovr       <= '0;
      mask      <= '0;
      state     <= S_IDLE;
      act_id    <= 3'd0;
      irq       <= 1'b0;
      rd_data_q <= 8'h00;
      rd_hit_q  <= 1'b0;
    end else begin
      src_q     <= src_req;
      pend      <= (pend & ~eoi_clr) | evt;
      ovr       <= (ovr | (evt & pend)) & ~eoi_clr;
      rd_data_q <= rd_next;
      rd_hit_q  <= hit_next;
      if (mask_wr) mask <= bus.out_port[NUM_SRC-1:0];
      case (state)
        S_IDLE: begin
          if (|req) begin
            act_id <= win_id;
            irq    <= 1'b1;
            state  <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (bus.interrupt_ack) begin
            irq   <= 1'b0;
            state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            act_id <= 3'd0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
